// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS tuning word from a start value to a stop
// value in clamped increments, holding each point for a dwell period.
// Supports single-shot and continuous-loop sweeps and produces the
// phase-accumulator clear pulse at the start of every sweep.
module dds_sweep_ctrl #(
  parameter int KW_WIDTH    = 28,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [KW_WIDTH-1:0]    cfg_start_kw,
  input  logic [KW_WIDTH-1:0]    cfg_stop_kw,
  input  logic [KW_WIDTH-1:0]    cfg_step_kw,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  input  logic                   start,
  input  logic                   abort,
  output logic [KW_WIDTH-1:0]    kw,
  output logic                   kw_valid,
  output logic                   acc_clr,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t r_state;
  state_t w_state_next;

  // Shadow config, writable only while idle.
  logic [KW_WIDTH-1:0]    r_cfg_start, r_cfg_stop, r_cfg_step;
  logic [DWELL_WIDTH-1:0] r_cfg_dwell;
  logic                   r_cfg_loop;

  // Working copy frozen at sweep start, so a config written in the same
  // cycle as start only affects the following sweep.
  logic [KW_WIDTH-1:0]    r_run_start, r_run_stop, r_run_step;
  logic [DWELL_WIDTH-1:0] r_run_reload;
  logic                   r_run_loop;
  logic                   r_up;

  logic [KW_WIDTH-1:0]    r_kw;
  logic                   r_kw_valid, r_acc_clr, r_done;
  logic [DWELL_WIDTH-1:0] r_cnt;

  logic [DWELL_WIDTH-1:0] w_shadow_reload;
  logic [KW_WIDTH:0]      w_sum;
  logic [KW_WIDTH-1:0]    w_diff;
  logic [KW_WIDTH-1:0]    w_next_kw;
  logic                   w_at_end;
  logic                   w_begin, w_count, w_advance, w_wrap, w_finish, w_abort;

  // A dwell of 0 behaves like 1: the counter reloads to max(dwell,1)-1.
  assign w_shadow_reload = (r_cfg_dwell == '0) ? '0 : r_cfg_dwell - DWELL_WIDTH'(1);

  // Clamped next point: widened add for the up direction so it cannot wrap,
  // distance-to-stop comparison for the down direction so it cannot undershoot.
  assign w_sum  = {1'b0, r_kw} + {1'b0, r_run_step};
  assign w_diff = r_kw - r_run_stop;
  always_comb begin
    w_next_kw = r_kw;
    if (r_up) begin
      w_next_kw = (w_sum >= {1'b0, r_run_stop}) ? r_run_stop : w_sum[KW_WIDTH-1:0];
    end else begin
      w_next_kw = (w_diff <= r_run_step) ? r_run_stop : (r_kw - r_run_step);
    end
  end

  // A zero step can never reach a different stop value, so it ends the pass.
  assign w_at_end = (r_kw == r_run_stop) || (r_run_step == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and per-cycle datapath actions; abort outranks all RUN moves.
  always_comb begin
    w_state_next = r_state;
    w_begin      = 1'b0;
    w_count      = 1'b0;
    w_advance    = 1'b0;
    w_wrap       = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_begin      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
          w_abort      = 1'b1;
        end else if (r_cnt != '0) begin
          w_count = 1'b1;
        end else if (!w_at_end) begin
          w_advance = 1'b1;
        end else if (r_run_loop) begin
          w_wrap = 1'b1;
        end else begin
          w_state_next = IDLE;
          w_finish     = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Config shadow, working copy, tuning word, dwell counter and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_start  <= '0;
      r_cfg_stop   <= '0;
      r_cfg_step   <= '0;
      r_cfg_dwell  <= '0;
      r_cfg_loop   <= 1'b0;
      r_run_start  <= '0;
      r_run_stop   <= '0;
      r_run_step   <= '0;
      r_run_reload <= '0;
      r_run_loop   <= 1'b0;
      r_up         <= 1'b1;
      r_kw         <= '0;
      r_kw_valid   <= 1'b0;
      r_acc_clr    <= 1'b0;
      r_done       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_acc_clr <= w_begin;
      r_done    <= w_finish;
      if (cfg_valid && (r_state == IDLE)) begin
        r_cfg_start <= cfg_start_kw;
        r_cfg_stop  <= cfg_stop_kw;
        r_cfg_step  <= cfg_step_kw;
        r_cfg_dwell <= cfg_dwell;
        r_cfg_loop  <= cfg_loop;
      end
      if (w_begin) begin
        r_run_start  <= r_cfg_start;
        r_run_stop   <= r_cfg_stop;
        r_run_step   <= r_cfg_step;
        r_run_reload <= w_shadow_reload;
        r_run_loop   <= r_cfg_loop;
        r_up         <= (r_cfg_stop >= r_cfg_start);
        r_kw         <= r_cfg_start;
        r_kw_valid   <= 1'b1;
        r_cnt        <= w_shadow_reload;
      end
      if (w_count) r_cnt <= r_cnt - DWELL_WIDTH'(1);
      if (w_advance) begin
        r_kw  <= w_next_kw;
        r_cnt <= r_run_reload;
      end
      if (w_wrap) begin
        r_kw  <= r_run_start;
        r_cnt <= r_run_reload;
      end
      if (w_finish) r_kw_valid <= 1'b0;
      if (w_abort) begin
        r_kw       <= '0;
        r_kw_valid <= 1'b0;
      end
    end
  end

  assign kw        = r_kw;
  assign kw_valid  = r_kw_valid;
  assign acc_clr   = r_acc_clr;
  assign done      = r_done;
  assign busy      = (r_state == RUN);
  assign cfg_ready = (r_state == IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: expected per-cycle outputs are queued
// when a sweep is launched and compared cycle by cycle as the DUT runs.
module tb_dds_sweep_ctrl;

  localparam int KW_WIDTH    = 28;
  localparam int DWELL_WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cfg_valid = 1'b0;
  logic                   cfg_ready;
  logic [KW_WIDTH-1:0]    cfg_start_kw = '0;
  logic [KW_WIDTH-1:0]    cfg_stop_kw = '0;
  logic [KW_WIDTH-1:0]    cfg_step_kw = '0;
  logic [DWELL_WIDTH-1:0] cfg_dwell = '0;
  logic                   cfg_loop = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [KW_WIDTH-1:0]    kw;
  logic                   kw_valid;
  logic                   acc_clr;
  logic                   busy;
  logic                   done;

  dds_sweep_ctrl #(.KW_WIDTH(KW_WIDTH), .DWELL_WIDTH(DWELL_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_kw(cfg_start_kw), .cfg_stop_kw(cfg_stop_kw),
    .cfg_step_kw(cfg_step_kw), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
    .start(start), .abort(abort),
    .kw(kw), .kw_valid(kw_valid), .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KW_WIDTH-1:0] kw;
    logic                v;
    logic                c;
    logic                b;
    logic                d;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string cur_test = "init";
  int    cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s cyc=%0d observed=%0h expected=%0h", cur_test, tag, cyc, obs, expv);
    end
  endtask

  task automatic push(input logic [KW_WIDTH-1:0] k, input logic v, input logic c,
                      input logic b, input logic d);
    exp_t e;
    e.kw = k; e.v = v; e.c = c; e.b = b; e.d = d;
    sb.push_back(e);
  endtask

  // Push n identical points.
  task automatic push_n(input int n, input logic [KW_WIDTH-1:0] k, input logic v,
                        input logic c, input logic b, input logic d);
    for (int i = 0; i < n; i++) push(k, v, c, b, d);
  endtask

  task automatic set_cfg(input logic [KW_WIDTH-1:0] s, input logic [KW_WIDTH-1:0] p,
                         input logic [KW_WIDTH-1:0] st, input logic [DWELL_WIDTH-1:0] dw,
                         input logic lp);
    cfg_start_kw = s; cfg_stop_kw = p; cfg_step_kw = st; cfg_dwell = dw; cfg_loop = lp;
  endtask

  // Write config in one idle cycle.
  task automatic load_cfg(input logic [KW_WIDTH-1:0] s, input logic [KW_WIDTH-1:0] p,
                          input logic [KW_WIDTH-1:0] st, input logic [DWELL_WIDTH-1:0] dw,
                          input logic lp);
    set_cfg(s, p, st, dw, lp);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Advance one cycle per queued entry and compare; one-shot inputs drop
  // after the first edge, start stays up when hold is set.
  task automatic drain(input bit hold);
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) start = 1'b0;
      abort = 1'b0;
      cfg_valid = 1'b0;
      e = sb.pop_front();
      $display("cyc=%0d %s kw=%0h v=%0b clr=%0b busy=%0b done=%0b rdy=%0b exp_kw=%0h",
               cyc, cur_test, kw, kw_valid, acc_clr, busy, done, cfg_ready, e.kw);
      chk("kw",        32'(kw),        32'(e.kw));
      chk("kw_valid",  32'(kw_valid),  32'(e.v));
      chk("acc_clr",   32'(acc_clr),   32'(e.c));
      chk("busy",      32'(busy),      32'(e.b));
      chk("done",      32'(done),      32'(e.d));
      chk("cfg_ready", 32'(cfg_ready), 32'(!e.b));
    end
  endtask

  task automatic chk_reset_state();
    chk("kw",        32'(kw),        32'd0);
    chk("kw_valid",  32'(kw_valid),  32'd0);
    chk("acc_clr",   32'(acc_clr),   32'd0);
    chk("busy",      32'(busy),      32'd0);
    chk("done",      32'(done),      32'd0);
    chk("cfg_ready", 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    cur_test = "reset";
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state();

    // Up sweep 100..130 step 10 dwell 3.
    cur_test = "up";
    load_cfg(28'd100, 28'd130, 28'd10, 16'd3, 1'b0);
    start = 1'b1;
    push(28'd100, 1, 1, 1, 0);
    push_n(2, 28'd100, 1, 0, 1, 0);
    push_n(3, 28'd110, 1, 0, 1, 0);
    push_n(3, 28'd120, 1, 0, 1, 0);
    push_n(3, 28'd130, 1, 0, 1, 0);
    push(28'd130, 0, 0, 0, 1);
    drain(1'b0);

    // Down sweep with clamp on the last step, dwell 0.
    cur_test = "down";
    load_cfg(28'd50, 28'd20, 28'd20, 16'd0, 1'b0);
    start = 1'b1;
    push(28'd50, 1, 1, 1, 0);
    push(28'd30, 1, 0, 1, 0);
    push(28'd20, 1, 0, 1, 0);
    push(28'd20, 0, 0, 0, 1);
    drain(1'b0);

    // Up sweep near full scale must clamp, not wrap.
    cur_test = "nowrap";
    load_cfg(28'hFFFFFF0, 28'hFFFFFFF, 28'h20, 16'd1, 1'b0);
    start = 1'b1;
    push(28'hFFFFFF0, 1, 1, 1, 0);
    push(28'hFFFFFFF, 1, 0, 1, 0);
    push(28'hFFFFFFF, 0, 0, 0, 1);
    drain(1'b0);

    // Loop sweep 0..4 step 2 dwell 2, config offered mid-run, then abort.
    cur_test = "loop";
    load_cfg(28'd0, 28'd4, 28'd2, 16'd2, 1'b1);
    start = 1'b1;
    push(28'd0, 1, 1, 1, 0);
    push(28'd0, 1, 0, 1, 0);
    push_n(2, 28'd2, 1, 0, 1, 0);
    drain(1'b0);
    cur_test = "cfg_in_run";
    set_cfg(28'd999, 28'd1, 28'd7, 16'd9, 1'b0);
    cfg_valid = 1'b1;
    push_n(2, 28'd4, 1, 0, 1, 0);
    push(28'd0, 1, 0, 1, 0);
    push(28'd0, 1, 0, 1, 0);
    push(28'd2, 1, 0, 1, 0);
    drain(1'b0);
    cur_test = "abort";
    abort = 1'b1;
    push(28'd0, 0, 0, 0, 0);
    drain(1'b0);
    cur_test = "abort_idle";
    abort = 1'b1;
    push(28'd0, 0, 0, 0, 0);
    drain(1'b0);

    // Config together with start: this sweep still uses the loop config.
    cur_test = "cfg_with_start";
    set_cfg(28'd77, 28'd200, 28'd0, 16'd5, 1'b0);
    cfg_valid = 1'b1;
    start = 1'b1;
    push(28'd0, 1, 1, 1, 0);
    push(28'd0, 1, 0, 1, 0);
    push(28'd2, 1, 0, 1, 0);
    drain(1'b0);
    abort = 1'b1;
    push(28'd0, 0, 0, 0, 0);
    drain(1'b0);

    // Next sweep picks up the new config: step 0 gives one point for 5 cycles.
    cur_test = "step0";
    start = 1'b1;
    push(28'd77, 1, 1, 1, 0);
    push_n(4, 28'd77, 1, 0, 1, 0);
    push(28'd77, 0, 0, 0, 1);
    drain(1'b0);

    // start held across completion restarts in the done cycle.
    cur_test = "b2b";
    load_cfg(28'd5, 28'd5, 28'd3, 16'd2, 1'b0);
    start = 1'b1;
    push(28'd5, 1, 1, 1, 0);
    push(28'd5, 1, 0, 1, 0);
    push(28'd5, 0, 0, 0, 1);
    push(28'd5, 1, 1, 1, 0);
    push(28'd5, 1, 0, 1, 0);
    drain(1'b1);
    start = 1'b0;
    push(28'd5, 0, 0, 0, 1);
    drain(1'b0);

    // Reset in the middle of a sweep clears everything, including shadow config.
    cur_test = "reset_mid";
    load_cfg(28'd10, 28'd100, 28'd10, 16'd4, 1'b0);
    start = 1'b1;
    push(28'd10, 1, 1, 1, 0);
    push_n(3, 28'd10, 1, 0, 1, 0);
    push(28'd20, 1, 0, 1, 0);
    drain(1'b0);
    rst = 1'b1;
    start = 1'b1;
    cfg_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    cfg_valid = 1'b0;
    start = 1'b1;
    cur_test = "after_reset";
    push(28'd0, 1, 1, 1, 0);
    push(28'd0, 0, 0, 0, 1);
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
